// File: rtl/bram_stream_pkg.sv
// Shared types for the BRAM stream reader: FSM states, output-buffer entry and pointer helper.
package bram_stream_pkg;

  localparam int DATA_W    = 32;
  localparam int BUF_DEPTH = 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } buf_entry_t;

  function automatic logic [1:0] buf_ptr_inc(input logic [1:0] ptr);
    return (ptr == 2'(BUF_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/bram_stream_buf.sv
// Small synchronous FIFO holding BRAM words until the stream consumer takes them.
// Push and pop may coincide; the reader's credit logic guarantees it never overflows.
module bram_stream_buf
  import bram_stream_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_reg [BUF_DEPTH];
  logic [1:0]   wr_ptr_reg;
  logic [1:0]   rd_ptr_reg;
  logic [1:0]   count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= buf_ptr_inc(wr_ptr_reg);
      end
      if (pop) rd_ptr_reg <= buf_ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a command's words sequentially from a 1-cycle-latency BRAM port and streams them out.
// Optional BRAM_STREAM_READER_LAST_EN adds out_last, marking the final word of each command.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int DATA  = 32,
  parameter int ADDR  = 7,
  parameter int DEPTH = 128
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [ADDR-1:0] cmd_addr,
  input  logic [ADDR:0]   cmd_len,
  output logic            read_enable,
  output logic [ADDR-1:0] read_addr,
  input  logic [DATA-1:0] read_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DATA-1:0] out_data,
`ifdef BRAM_STREAM_READER_LAST_EN
  output logic            out_last,
`endif
  output logic            done
);

  state_e          state_reg, state_next;
  logic [ADDR-1:0] addr_reg;
  logic [ADDR:0]   issue_left_reg;
  logic [ADDR:0]   words_left_reg;
  logic            land_reg;
  logic [1:0]      buf_count;
  logic [2:0]      committed;
  logic            pop;
  logic            accept;

  assign cmd_ready   = (state_reg == IDLE);
  assign accept      = cmd_valid & cmd_ready;
  assign out_valid   = (buf_count != 2'd0);
  assign pop         = out_valid & out_ready;
  // Slots already spoken for: buffered words plus the read landing next cycle, minus the word leaving now.
  assign committed   = 3'(buf_count) + 3'(land_reg) - 3'(pop);
  assign read_enable = (state_reg == RUN) && (committed < 3'(BUF_DEPTH));
  assign read_addr   = addr_reg;

  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    case (state_reg)
      IDLE:  if (accept) state_next = (cmd_len == '0) ? DRAIN : RUN;
      RUN:   if (read_enable && issue_left_reg == (ADDR+1)'(1)) state_next = DRAIN;
      DRAIN: begin
        // A zero-length command arrives here with nothing to pop and finishes at once.
        if (words_left_reg == '0 || (words_left_reg == (ADDR+1)'(1) && pop)) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg       <= '0;
      issue_left_reg <= '0;
      words_left_reg <= '0;
      land_reg       <= 1'b0;
    end else begin
      land_reg <= read_enable;
      if (accept) begin
        addr_reg       <= cmd_addr;
        issue_left_reg <= cmd_len;
        words_left_reg <= cmd_len;
      end else begin
        if (read_enable) begin
          addr_reg       <= (addr_reg == ADDR'(DEPTH - 1)) ? '0 : addr_reg + 1'b1;
          issue_left_reg <= issue_left_reg - 1'b1;
        end
        if (pop) words_left_reg <= words_left_reg - 1'b1;
      end
    end
  end

`ifdef BRAM_STREAM_READER_LAST_EN
  logic       land_last_reg;
  buf_entry_t push_entry;
  buf_entry_t head_entry;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) land_last_reg <= 1'b0;
    else          land_last_reg <= read_enable && (issue_left_reg == (ADDR+1)'(1));
  end

  assign push_entry = '{data: read_data, last: land_last_reg};

  bram_stream_buf #(.W($bits(buf_entry_t))) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (land_reg),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (buf_count)
  );

  assign out_data = head_entry.data;
  assign out_last = head_entry.last & out_valid;
`else
  bram_stream_buf #(.W(DATA)) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (land_reg),
    .push_data (read_data),
    .pop       (pop),
    .head_data (out_data),
    .count     (buf_count)
  );
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: BRAM model with mem[i]=i+0x100, queue-based reference model,
// per-cycle compare process plus directed literal checks.
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        read_enable;
  logic [6:0]  read_addr;
  logic [31:0] read_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        done;
`ifdef BRAM_STREAM_READER_LAST_EN
  logic        out_last;
`endif

  int total = 0;
  int bad = 0;
  int ready_mode = 0;  // 0: always ready, 1: random 50%, 2: driven by the test sequence

  bram_stream_reader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .read_enable (read_enable),
    .read_addr   (read_addr),
    .read_data   (read_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
`ifdef BRAM_STREAM_READER_LAST_EN
    .out_last    (out_last),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [128];
  initial for (int i = 0; i < 128; i++) mem[i] = 32'(i) + 32'h100;
  always @(posedge clk) if (read_enable) read_data <= mem[read_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: queue of expected words and read addresses, built from the command.
  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;
  exp_t       exp_q[$];
  logic [6:0] rd_q[$];
  int         outstanding = 0;
  bit         busy = 0;
  bit         len0_pending = 0;
  bit         prev_stall = 0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
      chk("rst_read_enable", 32'(read_enable), 32'(0));
      chk("rst_read_addr", 32'(read_addr), 32'(0));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_out_data", out_data, 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      exp_q.delete();
      rd_q.delete();
      outstanding = 0;
      busy = 0;
      len0_pending = 0;
      prev_stall = 0;
    end else begin
      automatic bit pop = out_valid && out_ready;
      automatic bit exp_done;
      chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
      if (read_enable) begin
        if (rd_q.size() == 0) fail_now("spurious_read");
        else chk("read_addr", 32'(read_addr), 32'(rd_q.pop_front()));
        outstanding++;
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'(1));
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && exp_q.size() == 0) fail_now("spurious_valid");
      if (pop && exp_q.size() != 0) begin
        automatic exp_t e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
`ifdef BRAM_STREAM_READER_LAST_EN
        chk("out_last", 32'(out_last), 32'(e.l));
`endif
        outstanding--;
        exp_done = (exp_q.size() == 0);
      end else begin
        exp_done = len0_pending;
      end
      len0_pending = 0;
      chk("done", 32'(done), 32'(exp_done));
      if (exp_done) busy = 0;
      chk("credit_le3", 32'(outstanding <= 3), 32'(1));
      if (cmd_valid && !busy) begin
        busy = 1;
        for (int i = 0; i < int'(cmd_len); i++) begin
          automatic int a = (int'(cmd_addr) + i) % 128;
          exp_q.push_back('{d: mem[a], l: (i == int'(cmd_len) - 1)});
          rd_q.push_back(7'(a));
        end
        if (cmd_len == 0) len0_pending = 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // One cycle: edge, then readiness update, then settle; callers act at posedge+2.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    #1;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 100 && !cmd_ready; n++) tick();
    if (!cmd_ready) fail_now("idle_timeout");
  endtask

  task automatic send(input logic [6:0] addr, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
    $display("cmd addr=%0d len=%0d accepted", addr, len);
  endtask

  task automatic wait_done(input bit junk);
    int n;
    for (n = 0; n < 3000; n++) begin
      if (done) break;
      if (junk) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_addr  = 7'($urandom);
        cmd_len   = 8'($urandom_range(0, 128));
      end
      tick();
    end
    cmd_valid = 1'b0;
    if (n == 3000) fail_now("done_timeout");
  endtask

  initial begin
    logic [6:0]  ea [4];
    logic [31:0] ed [4];
    int p;

    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Directed: addr 5, len 4 at full rate, cycle-exact latency.
    ready_mode = 0;
    tick();
    wait_idle();
    send(7'd5, 8'd4);
    chk("t1_re_c1", 32'(read_enable), 32'(1));
    chk("t1_addr_c1", 32'(read_addr), 32'(5));
    tick();
    chk("t1_valid_c2", 32'(out_valid), 32'(0));
    tick();
    chk("t1_valid_c3", 32'(out_valid), 32'(1));
    chk("t1_data_c3", out_data, 32'h105);
    chk("t1_done_c3", 32'(done), 32'(0));
    tick();
    chk("t1_data_c4", out_data, 32'h106);
    tick();
    chk("t1_data_c5", out_data, 32'h107);
    tick();
    chk("t1_data_c6", out_data, 32'h108);
    chk("t1_done_c6", 32'(done), 32'(1));
`ifdef BRAM_STREAM_READER_LAST_EN
    chk("t1_last_c6", 32'(out_last), 32'(1));
`endif
    tick();

    // Directed: wrap at the top of the BRAM.
    ea[0] = 7'd126; ea[1] = 7'd127; ea[2] = 7'd0; ea[3] = 7'd1;
    ed[0] = 32'h17E; ed[1] = 32'h17F; ed[2] = 32'h100; ed[3] = 32'h101;
    wait_idle();
    send(7'd126, 8'd4);
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) chk("t2_read_addr", 32'(read_addr), 32'(ea[c-1]));
      if (c >= 3) chk("t2_out_data", out_data, ed[c-3]);
      if (c == 6) chk("t2_done", 32'(done), 32'(1));
      tick();
    end

    // Stall for 20 cycles after the first word.
    ready_mode = 2;
    out_ready  = 1'b1;
    wait_idle();
    send(7'd40, 8'd10);
    p = 0;
    while (!out_valid && p < 20) begin
      tick();
      p++;
    end
    if (!out_valid) fail_now("t3_no_first_word");
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i >= 4) chk("t3_stalled_no_read", 32'(read_enable), 32'(0));
      tick();
    end
    chk("t3_valid_held", 32'(out_valid), 32'(1));
    out_ready = 1'b1;
    wait_done(0);

    // Zero-length command.
    ready_mode = 0;
    wait_idle();
    send(7'd9, 8'd0);
    chk("t4_done_next", 32'(done), 32'(1));
    chk("t4_no_read", 32'(read_enable), 32'(0));
    chk("t4_no_valid", 32'(out_valid), 32'(0));
    tick();
    chk("t4_no_valid_after", 32'(out_valid), 32'(0));

    // Full-depth command under random backpressure with junk command pulses.
    ready_mode = 1;
    wait_idle();
    send(7'd17, 8'd128);
    wait_done(1);

    // Random commands.
    repeat (12) begin
      wait_idle();
      send(7'($urandom), 8'($urandom_range(0, 40)));
      wait_done(1'($urandom_range(0, 1)));
    end

    // Reset mid-command after three words have been popped.
    ready_mode = 0;
    wait_idle();
    send(7'd60, 8'd20);
    p = 0;
    for (int n = 0; n < 50 && p < 3; n++) begin
      if (out_valid && out_ready) p++;
      tick();
    end
    if (p < 3) fail_now("t6_pop_timeout");
    reset_n = 1'b0;
    #1;
    chk("t6_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("t6_read_enable", 32'(read_enable), 32'(0));
    chk("t6_read_addr", 32'(read_addr), 32'(0));
    chk("t6_out_valid", 32'(out_valid), 32'(0));
    chk("t6_out_data", out_data, 32'(0));
    chk("t6_done", 32'(done), 32'(0));
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    wait_idle();
    send(7'd5, 8'd4);
    wait_done(0);
    wait_idle();
    send(7'd126, 8'd4);
    wait_done(0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
